// File: rtl/sdf_fft32_ctrl_if.sv
// Handshake and control bundle between the SDF FFT32 sequencing controller and
// the sample source / butterfly datapath.
interface sdf_fft32_ctrl_if;
  logic       in_valid;
  logic [1:0] state_1;
  logic [1:0] state_2;
  logic [1:0] state_3;
  logic [1:0] state_4;
  logic [1:0] state_5;
  logic [3:0] tw_idx_1;
  logic [3:0] tw_idx_2;
  logic [3:0] tw_idx_3;
  logic [3:0] tw_idx_4;
  logic       out_valid;
  logic       out_sof;
  logic       busy;
  logic       err;

  modport master (
    output in_valid,
    input  state_1, state_2, state_3, state_4, state_5,
    input  tw_idx_1, tw_idx_2, tw_idx_3, tw_idx_4,
    input  out_valid, out_sof, busy, err
  );

  modport slave (
    input  in_valid,
    output state_1, state_2, state_3, state_4, state_5,
    output tw_idx_1, tw_idx_2, tw_idx_3, tw_idx_4,
    output out_valid, out_sof, busy, err
  );
endinterface

// File: rtl/sdf_fft32_ctrl.sv
// Sequencing controller for the 32-point radix-2 SDF FFT: butterfly states,
// twiddle indices, output framing and input-protocol error detection.
module sdf_fft32_ctrl (
  input logic             clk,
  input logic             rst,
  sdf_fft32_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    READY = 2'b00,
    RUN   = 2'b01,
    DRAIN = 2'b10
  } fsm_e;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_FIRST  = 2'b01;
  localparam logic [1:0] ST_SECOND = 2'b10;
  localparam logic [1:0] ST_WAIT   = 2'b11;

  // Per-stage first-sample offset, delay, and O_k+M_k. The latter is both the
  // cycle the stage leaves WAITING and the drain cycle at which it goes idle.
  localparam logic [4:0][5:0] OFS = {6'd35, 6'd32, 6'd27, 6'd18, 6'd1};
  localparam logic [4:0][4:0] MDL = {5'd1, 5'd2, 5'd4, 5'd8, 5'd16};
  localparam logic [4:0][5:0] THR = {6'd36, 6'd34, 6'd31, 6'd26, 6'd17};
  localparam logic [5:0] OUT_START  = 6'd37;
  localparam logic [5:0] DRAIN_LAST = 6'd36;
  localparam logic [4:0] SOF_PHASE  = 5'd5;

  fsm_e            fsm_q, fsm_d;
  logic [4:0]      n_q, n_d;
  logic            lap_q, lap_d;
  logic            dlap_q, dlap_d;
  logic [4:0]      started_q, started_d;
  logic            out_started_q, out_started_d;
  logic [4:0][1:0] st_q, st_d;
  logic [3:0][3:0] tw_q, tw_d;
  logic            ov_q, ov_d;
  logic            sof_q, sof_d;
  logic            busy_q, busy_d;
  logic            err_q, err_d;

  logic [5:0]      t_next_s;
  logic [5:0]      d_next_s;
  logic            live_s;
  logic [4:0][4:0] c_s;

  // Controller FSM and stream/drain cycle counters (mod 32 plus lap flags).
  always_comb begin
    fsm_d  = fsm_q;
    n_d    = n_q;
    lap_d  = lap_q;
    dlap_d = dlap_q;
    err_d  = 1'b0;
    case (fsm_q)
      READY: begin
        lap_d  = 1'b0;
        dlap_d = 1'b0;
        if (bus.in_valid) begin
          fsm_d = RUN;
          n_d   = 5'd1;
        end else begin
          n_d   = 5'd0;
        end
      end
      RUN: begin
        if (!bus.in_valid && (n_q != 5'd0)) begin
          fsm_d = READY;
          err_d = 1'b1;
          n_d   = 5'd0;
          lap_d = 1'b0;
        end else begin
          if (!bus.in_valid) begin
            fsm_d = DRAIN;
          end else begin
            fsm_d = RUN;
          end
          n_d    = n_q + 5'd1;
          lap_d  = lap_q | (n_q == 5'd31);
          dlap_d = 1'b0;
        end
      end
      DRAIN: begin
        err_d = bus.in_valid;
        if ({dlap_q, n_q} == DRAIN_LAST) begin
          fsm_d  = READY;
          n_d    = 5'd0;
          lap_d  = 1'b0;
          dlap_d = 1'b0;
        end else begin
          n_d    = n_q + 5'd1;
          lap_d  = lap_q | (n_q == 5'd31);
          dlap_d = dlap_q | (n_q == 5'd31);
        end
      end
      default: begin
        fsm_d  = READY;
        n_d    = 5'd0;
        lap_d  = 1'b0;
        dlap_d = 1'b0;
      end
    endcase
  end

  // Next-cycle output values derived from the next counter/FSM values.
  always_comb begin
    t_next_s  = {lap_d, n_d};
    d_next_s  = {dlap_d, n_d};
    live_s    = (fsm_d != READY);
    c_s       = '0;
    started_d = '0;
    st_d      = '0;
    tw_d      = '0;
    for (int k = 0; k < 5; k++) begin
      c_s[k]       = n_d - OFS[k][4:0];
      started_d[k] = live_s && (started_q[k] || (t_next_s >= THR[k]));
      if ((fsm_d == RUN) || ((fsm_d == DRAIN) && (d_next_s < THR[k]))) begin
        if (started_d[k]) begin
          st_d[k] = ((c_s[k] & MDL[k]) != 5'd0) ? ST_FIRST : ST_SECOND;
        end else if (t_next_s >= OFS[k]) begin
          st_d[k] = ST_WAIT;
        end else begin
          st_d[k] = ST_IDLE;
        end
      end else begin
        st_d[k] = ST_IDLE;
      end
    end
    for (int k = 0; k < 4; k++) begin
      if (st_d[k] == ST_SECOND) begin
        tw_d[k] = (c_s[k][3:0] & (MDL[k][3:0] - 4'd1)) << k;
      end else begin
        tw_d[k] = 4'd0;
      end
    end
    out_started_d = live_s && (out_started_q || (t_next_s >= OUT_START));
    ov_d   = out_started_d &&
             ((fsm_d == RUN) || ((fsm_d == DRAIN) && (d_next_s < OUT_START)));
    sof_d  = ov_d && (n_d == SOF_PHASE);
    busy_d = live_s;
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q         <= READY;
      n_q           <= 5'd0;
      lap_q         <= 1'b0;
      dlap_q        <= 1'b0;
      started_q     <= 5'd0;
      out_started_q <= 1'b0;
      st_q          <= '0;
      tw_q          <= '0;
      ov_q          <= 1'b0;
      sof_q         <= 1'b0;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      fsm_q         <= fsm_d;
      n_q           <= n_d;
      lap_q         <= lap_d;
      dlap_q        <= dlap_d;
      started_q     <= started_d;
      out_started_q <= out_started_d;
      st_q          <= st_d;
      tw_q          <= tw_d;
      ov_q          <= ov_d;
      sof_q         <= sof_d;
      busy_q        <= busy_d;
      err_q         <= err_d;
    end
  end

  assign bus.state_1   = st_q[0];
  assign bus.state_2   = st_q[1];
  assign bus.state_3   = st_q[2];
  assign bus.state_4   = st_q[3];
  assign bus.state_5   = st_q[4];
  assign bus.tw_idx_1  = tw_q[0];
  assign bus.tw_idx_2  = tw_q[1];
  assign bus.tw_idx_3  = tw_q[2];
  assign bus.tw_idx_4  = tw_q[3];
  assign bus.out_valid = ov_q;
  assign bus.out_sof   = sof_q;
  assign bus.busy      = busy_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_sdf_fft32_ctrl.sv
// Directed self-checking bench for sdf_fft32_ctrl: reset, single and
// back-to-back frames, mid-frame drop, in_valid during drain, reset mid-run.
module tb_sdf_fft32_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  sdf_fft32_ctrl_if bus ();

  sdf_fft32_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Hand-computed spot vectors for the single-frame stream: (cycle, stage, state)
  int spot_t [12] = '{16, 17, 33, 49, 25, 26, 57, 58, 35, 36, 67, 68};
  int spot_k [12] = '{ 1,  1,  1,  1,  2,  2,  2,  2,  5,  5,  5,  5};
  int spot_v [12] = '{ 3,  1,  2,  0,  3,  1,  2,  0,  3,  1,  2,  0};

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int stage_ofs(input int k);
    case (k)
      1: return 1;
      2: return 18;
      3: return 27;
      4: return 32;
      5: return 35;
      default: return 0;
    endcase
  endfunction

  function automatic int stage_m(input int k);
    return 16 >> (k - 1);
  endfunction

  function automatic int exp_state(input int k, input int t, input int s);
    int c;
    int m;
    m = stage_m(k);
    c = t - stage_ofs(k);
    if (c < 0) return 0;
    if (c < m) return 3;
    if (c < s + m) return (((c / m) % 2) == 1) ? 1 : 2;
    return 0;
  endfunction

  function automatic int exp_tw(input int k, input int t, input int s);
    int c;
    c = t - stage_ofs(k);
    if (exp_state(k, t, s) != 2) return 0;
    return (c % stage_m(k)) * (1 << (k - 1));
  endfunction

  function automatic int obs_state(input int k);
    case (k)
      1: return int'(bus.state_1);
      2: return int'(bus.state_2);
      3: return int'(bus.state_3);
      4: return int'(bus.state_4);
      5: return int'(bus.state_5);
      default: return -1;
    endcase
  endfunction

  function automatic int obs_tw(input int k);
    case (k)
      1: return int'(bus.tw_idx_1);
      2: return int'(bus.tw_idx_2);
      3: return int'(bus.tw_idx_3);
      4: return int'(bus.tw_idx_4);
      default: return -1;
    endcase
  endfunction

  // t < 0 means "everything idle"
  task automatic check_outputs(input string pfx, input int t, input int s, input bit err_exp);
    int ov;
    ov = (t >= 37 && t <= 36 + s) ? 1 : 0;
    for (int k = 1; k <= 5; k++)
      check_eq($sformatf("%s state_%0d@%0d", pfx, k, t), obs_state(k), exp_state(k, t, s));
    for (int k = 1; k <= 4; k++)
      check_eq($sformatf("%s tw_idx_%0d@%0d", pfx, k, t), obs_tw(k), exp_tw(k, t, s));
    check_eq($sformatf("%s out_valid@%0d", pfx, t), int'(bus.out_valid), ov);
    check_eq($sformatf("%s out_sof@%0d", pfx, t), int'(bus.out_sof),
             (ov == 1 && ((t - 37) % 32) == 0) ? 1 : 0);
    check_eq($sformatf("%s busy@%0d", pfx, t), int'(bus.busy),
             (t >= 1 && t <= 36 + s) ? 1 : 0);
    check_eq($sformatf("%s err@%0d", pfx, t), int'(bus.err), int'(err_exp));
  endtask

  // One stream from cycle 0 to 'last'; pulse = drain-time in_valid (or -1),
  // drop = mid-frame cycle with in_valid low that aborts the stream (or -1).
  task automatic run_stream(input string pfx, input int s, input int pulse,
                            input int drop, input int last, input bit spots);
    for (int t = 0; t <= last; t++) begin
      @(posedge clk);
      #1;
      if (drop >= 0) bus.in_valid = (t < drop);
      else           bus.in_valid = (t < s) || (t == pulse);
      if (drop >= 0 && t == drop + 1) begin
        check_outputs({pfx, " abort"}, -1, s, 1'b1);
      end else begin
        check_outputs(pfx, t, s, (pulse >= 0) && (t == pulse + 1));
      end
      if (spots) begin
        for (int i = 0; i < 12; i++)
          if (spot_t[i] == t)
            check_eq($sformatf("%s spot_state_%0d@%0d", pfx, spot_k[i], t),
                     obs_state(spot_k[i]), spot_v[i]);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.in_valid = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      bus.in_valid = 1'($urandom_range(1));
      check_outputs("reset", -1, 32, 1'b0);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    rst = 1'b0;

    run_stream("single", 32, -1, -1, 72, 1'b1);
    run_stream("b2b", 64, -1, -1, 104, 1'b0);
    run_stream("drop", 64, -1, 20, 21, 1'b0);
    run_stream("after_drop", 32, -1, -1, 72, 1'b1);
    run_stream("drain_iv", 32, 40, -1, 72, 1'b1);

    run_stream("pre_rst", 64, -1, -1, 44, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    check_outputs("mid_rst", -1, 64, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_outputs("mid_rst_hold", -1, 64, 1'b0);
    rst = 1'b0;
    run_stream("post_rst", 32, -1, -1, 72, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
